lcd_screen_arbiter: RTL

Shares the single LCD frame path (RAM controller + LCD controller) between up to N_REQ screen producers: countdown, game, score and result screens. Each producer presents a full 128-bit frame and a request. The arbiter grants one producer, captures its frame and presents it to the RAM controller. It then holds ownership until the frame is written plus a minimum display time, so screens never interleave or flicker. It runs on the LCD-side divided clock.

---
 rtl/lcd_screen_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_screen_arbiter.sv
// lcd_screen_arbiter: lets one of N_REQ screen producers own the LCD frame
// path at a time. The granted frame is captured and held until it has been
// written and then displayed for a minimum time, so screens never interleave.
// Build option: define LCD_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// when it is left undefined the lowest requesting index wins.
module lcd_screen_arbiter #(
    parameter int N_REQ        = 4,
    parameter int IDX_W        = 2,
    parameter int FRAME_W      = 128,
    parameter int MIN_HOLD     = 1000,
    parameter int DONE_TIMEOUT = 20000,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*FRAME_W-1:0] frame_in_i,
    input  logic                     frame_done_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [IDX_W-1:0]         owner_o,
    output logic [FRAME_W-1:0]       frame_out_o,
    output logic                     frame_valid_o,
    output logic                     busy_o,
    output logic                     timeout_err_o
);

    // A HOLD of zero cycles would skip the display time entirely.
    localparam int HOLD_N = (MIN_HOLD < 1) ? 1 : MIN_HOLD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 fvalid_q, fvalid_d;
    logic                 busy_q, busy_d;
    logic                 terr_q, terr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 any_req;
    logic [IDX_W-1:0]     win_idx;

`ifdef LCD_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 found;
    int                   cand;

    // Round-robin winner: first requester at or after the slot following the last winner.
    always_comb begin
        any_req = |req_i;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr_q) + k) % N_REQ;
            if (!found && req_i[cand]) begin
                win_idx = IDX_W'(cand);
                found   = 1'b1;
            end
        end
    end
`else
    // Fixed-priority winner: the lowest requesting index.
    always_comb begin
        any_req = |req_i;
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Next-state logic: grant in IDLE, wait for the write in SHOW, display time in HOLD.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        frame_d  = frame_q;
        fvalid_d = fvalid_q;
        busy_d   = busy_q;
        terr_d   = 1'b0;
        cnt_d    = cnt_q;
`ifdef LCD_ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                gnt_d    = '0;
                fvalid_d = 1'b0;
                busy_d   = 1'b0;
                if (any_req) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    frame_d        = frame_in_i[int'(win_idx)*FRAME_W +: FRAME_W];
                    fvalid_d       = 1'b1;
                    busy_d         = 1'b1;
                    cnt_d          = '0;
                    state_d        = ST_SHOW;
`ifdef LCD_ARB_ROUND_ROBIN_EN
                    ptr_d          = win_idx;
`endif
                end
            end
            ST_SHOW: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done arriving on the timeout cycle wins over the watchdog.
                if (frame_done_i) begin
                    fvalid_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_HOLD;
                end else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) begin
                    fvalid_d = 1'b0;
                    terr_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                fvalid_d = 1'b0;
                if (cnt_q == CNT_W'(HOLD_N - 1)) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                fvalid_d = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // State and output registers; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            frame_q  <= '0;
            fvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            frame_q  <= frame_d;
            fvalid_q <= fvalid_d;
            busy_q   <= busy_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef LCD_ARB_ROUND_ROBIN_EN
    // Last-winner pointer; resets so that index 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(N_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign gnt_o         = gnt_q;
    assign owner_o       = owner_q;
    assign frame_out_o   = frame_q;
    assign frame_valid_o = fvalid_q;
    assign busy_o        = busy_q;
    assign timeout_err_o = terr_q;

endmodule
